// File: rtl/misr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : misr_gen
//  Brief    : Multiple-input signature register. It compacts N_IN response
//             bits per valid cycle into a WIDTH-bit signature over N_CYCLES
//             samples, then compares the result with a golden signature.
//  Revision : 1.0 - initial release
// ============================================================================
module misr_gen #(
    parameter int              WIDTH    = 21,
    parameter int              N_IN     = 3,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(21'h000001),
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(21'h16EDDB),
    parameter logic [WIDTH-1:0] GOLDEN  = '0,
    parameter int              N_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             valid,
    input  logic [N_IN-1:0]  e,
    input  logic             abort,
    output logic [WIDTH-1:0] hf,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    // The counter must hold values 0..N_CYCLES.
    localparam int             c_CW   = $clog2(N_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hf;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_inj;
    logic [WIDTH-1:0] w_hf_step;
    logic             w_last;
    logic             w_load;
    logic             w_step;

    // Shift toward bit 0; the top bit receives only feedback and input.
    assign w_shift = {1'b0, r_hf[WIDTH-1:1]};

    // Response bit j is injected at register bit WIDTH-1-j (top N_IN bits).
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= WIDTH - N_IN) begin : g_in
            assign w_inj[i] = e[WIDTH-1-i];
        end else begin : g_noin
            assign w_inj[i] = 1'b0;
        end
    end

    assign w_hf_step = w_shift ^ (POLY & {WIDTH{r_hf[0]}}) ^ w_inj;

    assign w_last = (r_cnt == c_LAST);
    assign w_load = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_step = valid && (r_state == ST_COMPACT);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start)           w_state_nxt = ST_COMPACT;
            ST_COMPACT: if (valid && w_last) w_state_nxt = ST_DONE;
            ST_DONE:    if (start)           w_state_nxt = ST_COMPACT;
            default:                         w_state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Signature register and sample counter; abort keeps the signature.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hf  <= SEED;
            r_cnt <= '0;
        end else if (abort) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_hf  <= SEED;
            r_cnt <= '0;
        end else if (w_step) begin
            r_hf  <= w_hf_step;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hf   = r_hf;
    assign busy = (r_state == ST_COMPACT);
    assign done = (r_state == ST_DONE);
    assign pass = (r_state == ST_DONE) && (r_hf == GOLDEN);

endmodule
`default_nettype wire

// File: tb/tb_misr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_misr_gen
//  Brief    : Self-checking bench for misr_gen. A four-sample instance and a
//             single-sample instance share one stimulus stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_misr_gen;

    localparam int         c_W      = 4;
    localparam logic [3:0] c_POLY   = 4'b1000;
    localparam logic [3:0] c_SEED   = 4'b0001;
    localparam logic [3:0] c_GOLDEN = 4'b1001;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic       valid;
    logic [1:0] e;
    logic       abort;

    logic [3:0] hf_a,   hf_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       pass_a, pass_b;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] m_hf;
    logic [3:0] sb_q[$];

    always #5 CLK = ~CLK;

    misr_gen #(
        .WIDTH(c_W), .N_IN(2), .POLY(c_POLY), .SEED(c_SEED),
        .GOLDEN(c_GOLDEN), .N_CYCLES(4)
    ) dut_a (
        .CLK(CLK), .RST(RST), .start(start), .valid(valid), .e(e),
        .abort(abort), .hf(hf_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    misr_gen #(
        .WIDTH(c_W), .N_IN(2), .POLY(c_POLY), .SEED(c_SEED),
        .GOLDEN(c_GOLDEN), .N_CYCLES(1)
    ) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .valid(valid), .e(e),
        .abort(abort), .hf(hf_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference step written bit by bit from the update equation.
    function automatic logic [3:0] mstep(input logic [3:0] h, input logic [1:0] ev);
        logic [3:0] r;
        logic       b;
        for (int i = 0; i < 4; i++) begin
            b = (i < 3) ? h[i+1] : 1'b0;
            b = b ^ (c_POLY[i] & h[0]);
            if (i >= 2) b = b ^ ev[3-i];
            r[i] = b;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        m_hf  = c_SEED;
        tick();
        start = 1'b0;
    endtask

    // Drive one compaction sample; expected signature goes to the scoreboard
    // and is popped once the DUT has clocked the sample in.
    task automatic sample(input logic [1:0] ev);
        valid = 1'b1;
        e     = ev;
        m_hf  = mstep(m_hf, ev);
        sb_q.push_back(m_hf);
        tick();
        valid = 1'b0;
        e     = 2'b00;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            chk("hf_sb", 64'(hf_a), 64'(sb_q.pop_front()));
        end
    endtask

    logic [3:0] c_seq31 [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [1:0] c_e33   [4] = '{2'b10, 2'b00, 2'b00, 2'b00};

    initial begin
        RST = 1'b1; start = 1'b0; valid = 1'b0; e = 2'b00; abort = 1'b0;
        tick();
        valid = 1'b1; e = 2'b11; start = 1'b1; abort = 1'b1;
        tick();
        chk("rst_hf",   64'(hf_a),   64'(c_SEED));
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_pass", 64'(pass_a), 64'd0);
        valid = 1'b0; e = 2'b00; start = 1'b0; abort = 1'b0;
        RST = 1'b0;
        tick();

        // Zero-input run: seed rotates through the register.
        do_start();
        chk("start_busy", 64'(busy_a), 64'd1);
        chk("start_hf",   64'(hf_a),   64'(c_SEED));
        for (int k = 0; k < 4; k++) begin
            sample(2'b00);
            chk("seq31", 64'(hf_a), 64'(c_seq31[k]));
            if (k == 0) begin
                chk("b_done1", 64'(done_b), 64'd1);
                chk("b_busy1", 64'(busy_b), 64'd0);
            end
            if (k < 3) chk("a_busy_mid", 64'(busy_a), 64'd1);
        end
        chk("a_done31", 64'(done_a), 64'd1);
        chk("a_busy31", 64'(busy_a), 64'd0);
        chk("a_pass31", 64'(pass_a), 64'd0);
        // Samples outside COMPACT are ignored.
        valid = 1'b1; e = 2'b11;
        tick();
        valid = 1'b0; e = 2'b00;
        chk("done_hold_hf", 64'(hf_a),   64'b0001);
        chk("done_hold",    64'(done_a), 64'd1);

        // Single sample with both inputs set.
        do_start();
        sample(2'b11);
        chk("hf32",    64'(hf_a),   64'b0100);
        chk("b_hf32",  64'(hf_b),   64'b0100);
        chk("b_done32", 64'(done_b), 64'd1);
        chk("b_busy32", 64'(busy_b), 64'd0);
        chk("a_done32", 64'(done_a), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_hf",   64'(hf_a),   64'b0100);
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("b_abort_done", 64'(done_b), 64'd0);

        // Interleaved valid pattern reaching the golden signature.
        do_start();
        for (int k = 0; k < 4; k++) begin
            sample(c_e33[k]);
            if (k < 3) begin
                chk("gap_done", 64'(done_a), 64'd0);
                e = 2'b11;
                tick();
                e = 2'b00;
                chk("gap_hf",   64'(hf_a),   64'(m_hf));
                chk("gap_done2", 64'(done_a), 64'd0);
                chk("gap_busy", 64'(busy_a), 64'd1);
            end
        end
        chk("gold_hf",   64'(hf_a),   64'(c_GOLDEN));
        chk("gold_done", 64'(done_a), 64'd1);
        chk("gold_pass", 64'(pass_a), 64'd1);
        tick();
        tick();
        chk("gold_hold", 64'(pass_a), 64'd1);

        // Abort beats start while in DONE.
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_hf",   64'(hf_a),   64'(c_GOLDEN));
        chk("ab_done", 64'(done_a), 64'd0);
        chk("ab_pass", 64'(pass_a), 64'd0);
        chk("ab_busy", 64'(busy_a), 64'd0);
        tick();
        chk("ab_idle", 64'(busy_a), 64'd0);

        // One flipped input bit spoils the signature.
        do_start();
        sample(2'b11);
        sample(2'b00);
        sample(2'b00);
        sample(2'b00);
        chk("bad_hf",   64'(hf_a),   64'b1000);
        chk("bad_done", 64'(done_a), 64'd1);
        chk("bad_pass", 64'(pass_a), 64'd0);

        // Reset mid-run; start during COMPACT is ignored.
        do_start();
        sample(2'b00);
        start = 1'b1;
        sample(2'b00);
        start = 1'b0;
        RST = 1'b1; valid = 1'b1; e = 2'b10;
        tick();
        RST = 1'b0; e = 2'b11;
        chk("mrst_hf",   64'(hf_a),   64'(c_SEED));
        chk("mrst_busy", 64'(busy_a), 64'd0);
        chk("mrst_done", 64'(done_a), 64'd0);
        tick();
        valid = 1'b0; e = 2'b00;
        chk("nostart_hf",   64'(hf_a),   64'(c_SEED));
        chk("nostart_busy", 64'(busy_a), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/misr_gen.md
MISR_GEN -- requirements
Module: misr_gen

Interface
REQ-001 SHALL support parameter WIDTH, default 21, signature register width; legal 2..64.
REQ-002 SHALL support parameter N_IN, default 3, parallel response inputs compacted per cycle; legal 1..WIDTH.
REQ-003 SHALL support parameter POLY, default 21'h000001, feedback tap mask, WIDTH bits; bit i set = s[0] fed into bit i.
REQ-004 SHALL support parameter SEED, default 21'h16EDDB, register value loaded on reset and on every start.
REQ-005 SHALL support parameter GOLDEN, default 0, expected fault-free signature, WIDTH bits.
REQ-006 SHALL support parameter N_CYCLES, default 1024, number of valid compaction cycles per run; legal 1..2^16.
REQ-007 SHALL have port CLK input 1, single clock; all state updates on its rising edge.
REQ-008 SHALL have port RST input 1, reset; synchronous, active-high.
REQ-009 SHALL have port start input 1, single-cycle request to begin a run.
REQ-010 SHALL have port valid input 1, e is a response sample to compact this cycle.
REQ-011 SHALL have port e input N_IN, circuit-under-test response bits.
REQ-012 SHALL have port abort input 1, terminate current run without verdict.
REQ-013 SHALL have port hf output WIDTH, current signature register contents (no extra pipeline stage).
REQ-014 SHALL have port busy output 1, high while in COMPACT.
REQ-015 SHALL have port done output 1, high while in DONE.
REQ-016 SHALL have port pass output 1, high only in DONE when hf == GOLDEN.

Function
REQ-017 SHALL implement states IDLE, COMPACT, DONE; busy = (state==COMPACT), done = (state==DONE), all registered.
REQ-018 SHALL, in IDLE or DONE on start=1, load hf <= SEED, clear cycle counter, enter COMPACT next cycle.
REQ-019 SHALL, in COMPACT with valid=1, update per bit i: hf'[i] = (i<WIDTH-1 ? hf[i+1] : 0) ^ (POLY[i] & hf[0]) ^ (i >= WIDTH-N_IN ? e[WIDTH-1-i] : 0).
REQ-020 SHALL, in COMPACT with valid=0, hold hf and counter unchanged.
REQ-021 SHALL count valid cycles in a ceil(log2(N_CYCLES+1))-bit counter; the update applying the N_CYCLES-th sample also moves state to DONE (signature final in same edge).
REQ-022 SHALL hold hf, done, pass stable in DONE until start, abort or RST.
REQ-023 SHALL ignore valid and e outside COMPACT (hf unchanged).
REQ-024 SHALL ignore start while in COMPACT.
REQ-025 SHALL, on abort=1 in any state, enter IDLE next cycle, keep hf as is, clear counter; abort has priority over start and valid in the same cycle.
REQ-026 SHALL compute pass combinationally from registered hf and state only; pass=0 outside DONE.
REQ-027 SHALL, with N_CYCLES=1, enter DONE after the first valid cycle.

Reset
REQ-028 SHALL, when RST=1 at a rising edge, set state IDLE, hf=SEED, counter=0, busy=0, done=0, pass=0, regardless of other inputs.
REQ-029 SHALL, on RST mid-run, discard partial signature; next run requires a new start.
REQ-030 SHALL have RST priority over abort, start and valid.

Verification
REQ-031 SHALL check: WIDTH=4, N_IN=2, POLY=4'b1000, SEED=4'b0001, start then valid with e=2'b00 -> hf 1000, 0100, 0010, 0001 over four cycles.
REQ-032 SHALL check: same config, start then one valid with e=2'b11 -> hf=4'b0100; with N_CYCLES=1 -> done=1, busy=0 next cycle.
REQ-033 SHALL check: N_CYCLES=4, valid toggled 1,0,1,0,1,0,1 -> done asserts only after the fourth valid cycle; hf unchanged on valid=0 cycles.
REQ-034 SHALL check: GOLDEN equal to computed signature -> pass=1 in DONE; single flipped bit of e in one cycle -> pass=0.
REQ-035 SHALL check: RST mid-COMPACT -> next cycle hf=SEED, busy=0, done=0; valid without start leaves hf=SEED.
REQ-036 SHALL check: abort and start asserted together in DONE -> IDLE, hf unchanged, done=0, pass=0.
